// File: rtl/snes_multi_poller_if.sv
// Bus-side port bundle of the SNES pad poller: request/read controls in,
// committed button state and frame status out.
interface snes_multi_poller_if #(
  parameter int NUM_PADS = 4,
  parameter int NUM_BITS = 12
);
  localparam int ADDR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic                auto_poll;
  logic                poll_req;
  logic [ADDR_W-1:0]   address;
  logic                read_enable;
  logic [NUM_BITS-1:0] read_data;
  logic [NUM_BITS-1:0] read_pressed;
  logic [NUM_PADS-1:0] pad_present;
  logic                frame_done;
  logic                busy;

  modport master (
    output auto_poll, poll_req, address, read_enable,
    input  read_data, read_pressed, pad_present, frame_done, busy
  );

  modport slave (
    input  auto_poll, poll_req, address, read_enable,
    output read_data, read_pressed, pad_present, frame_done, busy
  );
endinterface

// File: rtl/snes_multi_poller.sv
// Polls NUM_PADS SNES controllers on a shared latch/pulse pair and keeps
// committed button words, sticky press-edge flags and presence per pad.
module snes_pad_lane #(
  parameter int NUM_BITS = 12
)(
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic                sample,
  input  logic                din_n,
  input  logic                commit,
  input  logic                clr,
  output logic [NUM_BITS-1:0] committed,
  output logic [NUM_BITS-1:0] pressed,
  output logic                present
);
  logic [NUM_BITS-1:0] shift;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      shift     <= '0;
      committed <= '0;
      pressed   <= '0;
      present   <= 1'b0;
    end else begin
      if (sample) shift <= {shift[NUM_BITS-2:0], ~din_n};
      if (commit) begin
        committed <= shift;
        // pull-downs make a missing pad read as every button held
        present   <= ~(&shift);
        // a read in the commit cycle clears old flags, new edges still land
        pressed   <= (clr ? '0 : pressed) | (shift & ~committed);
      end else if (clr) begin
        pressed <= '0;
      end
    end
  end
endmodule

module snes_multi_poller #(
  parameter int NUM_PADS        = 4,
  parameter int NUM_BITS        = 12,
  parameter int HALF_PERIOD     = 2,
  parameter int LATCH_CYCLES    = 4,
  parameter int COOLDOWN_CYCLES = 12500
)(
  input  logic                sys_clk,
  input  logic                sys_reset,
  snes_multi_poller_if.slave  bus,
  input  logic [NUM_PADS-1:0] snes_data,
  output logic                snes_latch,
  output logic                snes_pulse
);
  localparam int ADDR_W  = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int MAX_A   = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int MAX_CNT = (MAX_A > COOLDOWN_CYCLES) ? MAX_A : COOLDOWN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = $clog2(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    PULSE_LO = 3'd2,
    PULSE_HI = 3'd3,
    COMMIT   = 3'd4,
    COOLDOWN = 3'd5
  } state_t;

  state_t                             state, state_n;
  logic [CNT_W-1:0]                   cnt, cnt_n;
  logic [BIT_W-1:0]                   bit_cnt, bit_n;
  logic                               sample, commit;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  committed, pressed;
  logic [NUM_PADS-1:0]                present, clr;
  logic                               addr_ok;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    bit_n   = bit_cnt;
    sample  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (bus.auto_poll || bus.poll_req || bus.read_enable) state_n = LATCH;
      end
      LATCH: if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
        state_n = PULSE_LO;
        cnt_n   = '0;
        sample  = 1'b1;
      end
      PULSE_LO: if (cnt == CNT_W'(HALF_PERIOD - 1)) begin
        cnt_n   = '0;
        state_n = (bit_cnt == BIT_W'(NUM_BITS - 1)) ? COMMIT : PULSE_HI;
      end
      PULSE_HI: if (cnt == CNT_W'(HALF_PERIOD - 1)) begin
        state_n = PULSE_LO;
        cnt_n   = '0;
        sample  = 1'b1;
        bit_n   = bit_cnt + BIT_W'(1);
      end
      COMMIT: begin
        state_n = COOLDOWN;
        cnt_n   = '0;
        commit  = 1'b1;
      end
      COOLDOWN: if (cnt == CNT_W'(COOLDOWN_CYCLES - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  // pin and status outputs are registered off next-state so they are glitch-free
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      snes_latch     <= 1'b0;
      snes_pulse     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_cnt        <= bit_n;
      snes_latch     <= (state_n == LATCH);
      snes_pulse     <= (state_n == PULSE_HI);
      bus.frame_done <= (state_n == COMMIT);
      bus.busy       <= (state_n != IDLE);
    end
  end

  assign addr_ok = 32'(bus.address) < NUM_PADS;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
    assign clr[p] = bus.read_enable && (bus.address == ADDR_W'(p));
    snes_pad_lane #(.NUM_BITS(NUM_BITS)) u_lane (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .sample    (sample),
      .din_n     (snes_data[p]),
      .commit    (commit),
      .clr       (clr[p]),
      .committed (committed[p]),
      .pressed   (pressed[p]),
      .present   (present[p])
    );
  end

  assign bus.pad_present = present;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      bus.read_data    <= '0;
      bus.read_pressed <= '0;
    end else if (bus.read_enable) begin
      bus.read_data    <= addr_ok ? committed[bus.address] : '0;
      bus.read_pressed <= addr_ok ? pressed[bus.address]   : '0;
    end
  end
endmodule
